// File: rtl/sap_pkg.sv
// Shared SAP definitions: default memory geometry and the program-loader state encoding.
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        WRITE     = 3'd2,
        CHECK     = 3'd3,
        FINISH    = 3'd4
    } loader_state_t;

    // States in which a load is in progress and the CPU must be held.
    function automatic logic loader_active(input loader_state_t s);
        return (s == WAIT_BYTE) || (s == WRITE) || (s == CHECK);
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and program-memory write port of the SAP memory loader.
interface mem_loader_if #(
    parameter int ADDR_W = sap_pkg::SAP_ADDR_W,
    parameter int DATA_W = sap_pkg::SAP_DATA_W
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_write, mem_adr, mem_data
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_write, mem_adr, mem_data
    );
endinterface

// File: rtl/mem_loader_timer.sv
// Inter-byte timeout for the memory loader: reloads on clear, counts down while enabled,
// flags expiry on the last allowed cycle. TIMEOUT_CYCLES = 0 disables expiry.
module loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge sysclk) begin
        if (reset || clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // Remaining count of zero is the elapsed count reaching TIMEOUT_CYCLES-1.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == '0);

endmodule

// File: rtl/mem_loader.sv
// SAP program-memory loader: streams DEPTH bytes into memory under cpu_hold, one write per clken.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing checksum byte (sum of all bytes == 0 mod 2**DATA_W).
//
//   state     | meaning
//   IDLE      | after reset, no load has run
//   WAIT_BYTE | rx_ready high, waiting for the next byte (timeout running)
//   WRITE     | mem_write high, holding adr/data until a clken edge commits
//   CHECK     | waiting for the checksum byte (checksum build only)
//   FINISH    | load ended; done or error tells how
module mem_loader
    import sap_pkg::*;
#(
    parameter int          ADDR_W         = SAP_ADDR_W,
    parameter int          DATA_W         = SAP_DATA_W,
    parameter int          DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clken,
    input  logic start,
    mem_loader_if.master bus,
    output logic cpu_hold,
    output logic busy,
    output logic done,
    output logic error
);
    loader_state_t state_q, state_d;

    logic              rx_ready_c;
    logic              mem_write_c;
    logic              accept;
    logic              start_ok;
    logic              last_adr;
    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_expired;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              error_q;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              sum_ok;
    assign sum_ok = (DATA_W'(sum_q + bus.rx_data) == '0);
`endif

    assign accept     = bus.rx_valid && rx_ready_c;
    assign start_ok   = start && ((state_q == IDLE) || (state_q == FINISH));
    assign last_adr   = (adr_q == ADDR_W'(DEPTH - 1));
    assign tmr_clear  = start_ok || accept;
    assign tmr_enable = rx_ready_c && !accept;

    loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FINISH: begin
                if (start) state_d = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                if (accept)           state_d = WRITE;
                else if (tmr_expired) state_d = FINISH;
            end
            WRITE: begin
                if (clken) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_d = last_adr ? CHECK : WAIT_BYTE;
`else
                    state_d = last_adr ? FINISH : WAIT_BYTE;
`endif
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept || tmr_expired) state_d = FINISH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ready_c  = (state_q == WAIT_BYTE) || (state_q == CHECK);
        mem_write_c = (state_q == WRITE);
        busy        = loader_active(state_q);
        cpu_hold    = loader_active(state_q);
    end

    // Datapath: address, held write data, sticky status flags and running sum.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            adr_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    if (start) begin
                        adr_q   <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                WAIT_BYTE: begin
                    if (accept) begin
                        data_q <= bus.rx_data;
`ifdef MEM_LOADER_CHECKSUM_EN
                        sum_q  <= sum_q + bus.rx_data;
`endif
                    end else if (tmr_expired) begin
                        error_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (clken) begin
                        if (!last_adr) begin
                            adr_q <= adr_q + ADDR_W'(1);
                        end
`ifndef MEM_LOADER_CHECKSUM_EN
                        else begin
                            done_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (sum_ok) done_q  <= 1'b1;
                        else        error_q <= 1'b1;
                    end else if (tmr_expired) begin
                        error_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_c;
    assign bus.mem_write = mem_write_c;
    assign bus.mem_adr   = adr_q;
    assign bus.mem_data  = data_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected memory writes, a monitor checks commits.
module tb_mem_loader;
    import sap_pkg::*;

    logic sysclk = 1'b0;
    logic reset;
    logic clken;
    logic start;
    logic cpu_hold, busy, done, error;

    int checks = 0;
    int errors = 0;

    logic        clken_en;
    int          cyc = 0;
    logic [3:0]  exp_adr;
    logic [11:0] exp_q[$];
    logic [7:0]  mem_model[16];
    logic [15:0] written;

    logic [7:0] stream[16] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h14, 8'h05, 8'h06,
                               8'h07, 8'h0F, 8'h0E, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    mem_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    mem_loader #(
        .ADDR_W(4), .DATA_W(8), .DEPTH(16), .TIMEOUT_CYCLES(50)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .clken   (clken),
        .start   (start),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "watchdog");
    end

    // clken strobe every 4th cycle while enabled
    initial begin
        clken = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            cyc++;
            clken = clken_en && (cyc % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'b0, bus.rx_ready, bus.mem_write, bus.mem_adr, bus.mem_data,
                cpu_hold, busy, done, error};
    endfunction

    // Monitor: a write commits at the coming edge when mem_write and clken are both high.
    always @(negedge sysclk) begin
        if (!reset && bus.mem_write && clken) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_adr", {28'b0, bus.mem_adr}, 32'hFFFF_FFFF);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("write_adr", {28'b0, bus.mem_adr}, {28'b0, e[11:8]});
                chk("write_data", {24'b0, bus.mem_data}, {24'b0, e[7:0]});
            end
            mem_model[bus.mem_adr] = bus.mem_data;
            written[bus.mem_adr]   = 1'b1;
        end
    end

    task automatic start_load();
        exp_adr = '0;
        written = '0;
        exp_q.delete();
        start = 1'b1;
        @(posedge sysclk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge sysclk);
        while (!bus.rx_ready && n < 500) begin
            @(negedge sysclk);
            n++;
        end
        chk("accept_bound", {31'b0, bus.rx_ready}, 32'd1);
        if (bus.rx_ready) begin
            if (push) begin
                exp_q.push_back({exp_adr, b});
                exp_adr++;
            end
            @(posedge sysclk);
            #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge sysclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge sysclk);
        while (busy && n < 2000) begin
            @(negedge sysclk);
            n++;
        end
        chk("wait_idle_bound", {31'b0, busy}, 32'd0);
    endtask

    task automatic expect_end(input logic exp_done, input logic exp_err);
        wait_idle();
        chk("done", {31'b0, done}, {31'b0, exp_done});
        chk("error", {31'b0, error}, {31'b0, exp_err});
        chk("cpu_hold_low", {31'b0, cpu_hold}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic send_tail(input logic [7:0] ck);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(ck, 1'b0);
`else
        chk("tail_unused", {24'b0, ck}, {24'b0, ck ^ 8'h00});
`endif
    endtask

    task automatic load_all(input int pulse_idx, input logic [7:0] ck);
        start_load();
        chk("cpu_hold_during_load", {30'b0, cpu_hold, busy}, 32'd3);
        for (int i = 0; i < 16; i++) begin
            send_byte(stream[i], 1'b1);
            if (i == pulse_idx) pulse_start();
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(ck, 1'b0);
`endif
    endtask

    initial begin
        int  n;
        logic bad;
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        clken_en     = 1'b1;
        written      = '0;
        exp_adr      = '0;
        for (int i = 0; i < 16; i++) mem_model[i] = 8'hA5;
        repeat (3) @(posedge sysclk);
        #1;
        reset = 1'b0;
        @(negedge sysclk);
        chk("reset_outputs", outs(), 32'd0);

        // Full load
        load_all(-1, 8'h9E);
        expect_end(1'b1, 1'b0);
        chk("final_adr", {28'b0, bus.mem_adr}, 32'd15);
        chk("all_written", {16'b0, written}, 32'h0000_FFFF);
        for (int i = 0; i < 16; i++)
            chk("readback", {24'b0, mem_model[i]}, {24'b0, stream[i]});

`ifdef MEM_LOADER_CHECKSUM_EN
        // Bad checksum: memory still receives all 16 bytes
        load_all(-1, 8'h9F);
        expect_end(1'b0, 1'b1);
        chk("all_written_badsum", {16'b0, written}, 32'h0000_FFFF);
        for (int i = 0; i < 16; i++)
            chk("readback_badsum", {24'b0, mem_model[i]}, {24'b0, stream[i]});
`else
        // A 17th byte after done must not be consumed
        bad = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h9E;
        repeat (10) begin
            @(negedge sysclk);
            if (bus.rx_ready) bad = 1'b1;
        end
        bus.rx_valid = 1'b0;
        chk("no_17th_accept", {31'b0, bad}, 32'd0);
`endif

        // clken stall while in WRITE
        clken_en = 1'b0;
        start_load();
        send_byte(stream[0], 1'b1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = stream[1];
        bad = 1'b0;
        repeat (200) begin
            @(negedge sysclk);
            if (bus.mem_write !== 1'b1 || bus.mem_adr !== 4'd0 ||
                bus.mem_data !== stream[0] || bus.rx_ready !== 1'b0) bad = 1'b1;
        end
        chk("stall_stable", {31'b0, bad}, 32'd0);
        clken_en = 1'b1;
        for (int i = 1; i < 16; i++) send_byte(stream[i], 1'b1);
        send_tail(8'h9E);
        expect_end(1'b1, 1'b0);
        chk("all_written_stall", {16'b0, written}, 32'h0000_FFFF);

        // start while busy is ignored
        load_all(5, 8'h9E);
        expect_end(1'b1, 1'b0);
        chk("final_adr_busy_start", {28'b0, bus.mem_adr}, 32'd15);
        chk("all_written_busy_start", {16'b0, written}, 32'h0000_FFFF);

        // Timeout after three bytes
        start_load();
        for (int i = 0; i < 3; i++) send_byte(stream[i], 1'b1);
        n = 0;
        @(negedge sysclk);
        while (!bus.rx_ready && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        chk("back_to_wait", {31'b0, bus.rx_ready}, 32'd1);
        n = 0;
        while (!error && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        chk("timeout_cycles", n, 32'd50);
        chk("timeout_busy", {31'b0, busy}, 32'd0);
        chk("timeout_done", {31'b0, done}, 32'd0);
        chk("timeout_written", {16'b0, written}, 32'h0000_0007);
        chk("timeout_queue", exp_q.size(), 32'd0);

        // Reset mid-load after byte 7 is accepted
        start_load();
        for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b1);
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge sysclk);
        chk("reset_midload_outputs", outs(), 32'd0);
        chk("reset_midload_written", {16'b0, written}, 32'h0000_007F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
